multi_channel_selector: RTL

- Parametrised successor of the two-switch channel processor.
- Holds the active display channel for NUM_CH sources and accepts channel write/read commands over the valid/ack register bus.
- Steps channel forward/backward from debounced buttons; falls back to channel 0 when the active source is disabled.
- Sits between the command decoder and the VGA source mux; drives the mux select.

---
 rtl/multi_channel_selector.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/multi_channel_selector.sv
// Active display channel register for NUM_CH sources: bus write/read commands, button stepping, fallback.
// Optional CH_RESTORE_EN: return to a channel lost through fallback once its source reappears.
module multi_channel_selector #(
    parameter int                NUM_CH    = 4,
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 4,
    parameter logic [ADDR_W-1:0] CH_ADDR   = ADDR_W'(2),
    parameter logic [DATA_W-1:0] READ_CODE = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              next,
    input  logic              prev,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic [$clog2(NUM_CH)-1:0] channel,
    output logic              channel_changed
);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic {IDLE, ACK} state_t;

    state_t            state_q, state_d;
    logic              next_p0, prev_p0;
    logic              accept, is_read, wr_req, wr_ok;
    logic              next_edge, prev_edge, step_req;
    logic              fallback, restore_hit, wr_take, step_take;
    logic [CH_W-1:0]   wr_ch, restore_ch, chan_d;
    logic              ack_d, err_d, dval_d;
    logic [DATA_W-1:0] dout_d;

    function automatic logic allowed(input logic [CH_W-1:0] r, input logic [NUM_CH-1:0] en);
        return (r == '0) || ((33'(r) < 33'(NUM_CH)) && en[r]);
    endfunction

    // Scan downward so the last hit is the smallest allowed index above cur.
    function automatic logic [CH_W-1:0] step_up(input logic [CH_W-1:0] cur, input logic [NUM_CH-1:0] en);
        logic [CH_W-1:0] res;
        res = '0;
        for (int i = NUM_CH - 1; i >= 1; i--)
            if (i > int'(cur) && en[i]) res = CH_W'(i);
        return res;
    endfunction

    // From 0 the target is the highest allowed index; otherwise the largest allowed below cur.
    function automatic logic [CH_W-1:0] step_down(input logic [CH_W-1:0] cur, input logic [NUM_CH-1:0] en);
        logic [CH_W-1:0] res;
        res = '0;
        for (int i = 1; i < NUM_CH; i++)
            if (en[i] && (cur == '0 || i < int'(cur))) res = CH_W'(i);
        return res;
    endfunction

    assign accept    = (state_q == IDLE) && valid && (address == CH_ADDR);
    assign is_read   = (data == READ_CODE);
    assign wr_req    = accept && !is_read;
    assign wr_ch     = data[CH_W-1:0];
    assign wr_ok     = (33'(data) < 33'(NUM_CH)) && allowed(wr_ch, ch_en);
    assign next_edge = next && !next_p0;
    assign prev_edge = prev && !prev_p0;
    assign step_req  = next_edge ^ prev_edge;
    assign fallback  = (channel != '0) && !ch_en[channel];
    assign wr_take   = !fallback && !restore_hit && wr_req && wr_ok;
    assign step_take = !fallback && !restore_hit && !wr_req && step_req;

`ifdef CH_RESTORE_EN
    logic            pending;
    logic [CH_W-1:0] saved_ch;

    assign restore_hit = pending && ch_en[saved_ch];
    assign restore_ch  = saved_ch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pending <= 1'b0;
        else if (fallback)
            pending <= 1'b1;
        else if (restore_hit || wr_take || step_take)
            pending <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (fallback) saved_ch <= channel;
    end
`else
    assign restore_hit = 1'b0;
    assign restore_ch  = '0;
`endif

    always_comb begin
        chan_d = channel;
        if (fallback)
            chan_d = '0;
        else if (restore_hit)
            chan_d = restore_ch;
        else if (wr_take)
            chan_d = wr_ch;
        else if (step_take)
            chan_d = next_edge ? step_up(channel, ch_en) : step_down(channel, ch_en);
    end

    // Command FSM: state register, next-state logic, registered-output preparation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d  = accept;
        err_d  = wr_req && !wr_ok;
        dval_d = accept && is_read;
        dout_d = dval_d ? DATA_W'(channel) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_p0         <= 1'b0;
            prev_p0         <= 1'b0;
            channel         <= '0;
            channel_changed <= 1'b0;
            ack             <= 1'b0;
            err             <= 1'b0;
            data_out        <= '0;
            data_out_valid  <= 1'b0;
        end else begin
            next_p0         <= next;
            prev_p0         <= prev;
            channel         <= chan_d;
            channel_changed <= (chan_d != channel);
            ack             <= ack_d;
            err             <= err_d;
            data_out        <= dout_d;
            data_out_valid  <= dval_d;
        end
    end
endmodule
